lm07_spi_responder: RTL and testbench

Synthesizable SPI temperature-sensor responder: the target side of the 3-wire LM07 read interface. It holds a temperature word written by local logic and, while the external master holds CS low, shifts it out MSB-first on SIO, advancing one bit per SCK falling edge. CS and SCK are oversampled in the single system clock domain. It sits in the sensor-emulation path, so the tt_um LM07 reader can be exercised against real silicon or an FPGA without a physical LM07.

---
 rtl/lm07_spi_responder_if.sv | 26 ++
 rtl/lm07_spi_responder.sv | 111 +++++++++++
 tb/tb_lm07_spi_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lm07_spi_responder_if.sv
// Bus bundle for the LM07 responder: local word-write handshake plus the 3-wire SPI pins.
interface lm07_spi_responder_if #(
    parameter int unsigned WORD_W = 16
);
    logic [WORD_W-1:0] temp_in;
    logic              temp_valid;
    logic              temp_ready;
    logic              cs_in;
    logic              sck_in;
    logic              sio_out;
    logic              sio_oe;
    logic              frame_done;
    logic              frame_abort;

    // Producer / SPI-master side.
    modport master (
        output temp_in, temp_valid, cs_in, sck_in,
        input  temp_ready, sio_out, sio_oe, frame_done, frame_abort
    );

    // Responder side.
    modport slave (
        input  temp_in, temp_valid, cs_in, sck_in,
        output temp_ready, sio_out, sio_oe, frame_done, frame_abort
    );
endinterface

// File: rtl/lm07_spi_responder.sv
// LM07 3-wire SPI responder: publishes a held temperature word MSB-first while CS is low,
// advancing one bit per SCK falling edge. CS/SCK are oversampled in the clk domain.
module lm07_spi_responder #(
    parameter int unsigned WORD_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    lm07_spi_responder_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] WordCnt = CNT_W'(WORD_W);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, vld_q;
    logic                   cs_prev_q, sck_prev_q, armed_q;
    logic                   cs_s, sck_s, cs_fall, cs_rise, sck_fall;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] hold_q, hold_d, shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              done_q, done_d, abort_q, abort_d;

    assign cs_s  = cs_sync_q[SYNC_STAGES-1];
    assign sck_s = sck_sync_q[SYNC_STAGES-1];

    // Synchronizers, edge-detect flops and the CS arming flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q  <= '1;
            sck_sync_q <= '0;
            cs_prev_q  <= 1'b1;
            sck_prev_q <= 1'b0;
            vld_q      <= '0;
            armed_q    <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_in};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck_in};
            cs_prev_q  <= cs_s;
            sck_prev_q <= sck_s;
            vld_q      <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            // Reset preloads CS high; only a genuinely sampled high CS may arm a frame start.
            armed_q    <= armed_q | (vld_q[SYNC_STAGES-1] & cs_s);
        end
    end

    assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign sck_fall = sck_prev_q & ~sck_s;

    // Frame state, hold/shift registers and the completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    // Next-state: load on CS fall, shift on SCK fall, finish on CS rise (which beats SCK).
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        if (bus.temp_valid && bus.temp_ready) begin
            hold_d = bus.temp_in;
        end
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    shift_d   = hold_q;
                    bit_cnt_d = '0;
                    state_d   = StActive;
                end
            end
            StActive: begin
                if (cs_rise) begin
                    state_d = StIdle;
                    done_d  = (bit_cnt_q == WordCnt);
                    abort_d = (bit_cnt_q != WordCnt);
                end else if (sck_fall && bit_cnt_q != WordCnt) begin
                    shift_d   = {shift_q[WORD_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Outputs decode straight from state so reset drops sio_oe asynchronously.
    always_comb begin
        bus.temp_ready  = (state_q == StIdle) && !cs_fall;
        bus.sio_oe      = (state_q == StActive);
        bus.sio_out     = (state_q == StActive) && shift_q[WORD_W-1];
        bus.frame_done  = done_q;
        bus.frame_abort = abort_q;
    end
endmodule

// File: tb/tb_lm07_spi_responder.sv
// Directed bench for lm07_spi_responder: drives an SPI master and a word producer.
module tb_lm07_spi_responder;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    lm07_spi_responder_if #(.WORD_W(16)) bus ();

    lm07_spi_responder #(
        .WORD_W      (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_word(input string tag, input logic [15:0] v);
        bit ok = 1'b0;
        @(negedge clk);
        bus.temp_in    = v;
        bus.temp_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.temp_ready) ok = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        bus.temp_valid = 1'b0;
        check_eq({tag, "_wr"}, 32'(ok), 32'd1);
    endtask

    // Runs one frame of nsck SCK pulses; master samples SIO as it raises SCK.
    task automatic run_frame(input string tag, input int nsck, input logic [31:0] exp_data,
                             input bit exp_done, input bit mid_write, input logic [15:0] mid_val);
        logic [31:0] data = '0;
        bit oe_ok = 1'b1, rdy_blocked = 1'b1;
        int done_n = 0, abort_n = 0, pulse_at = -1, xfer_at = -1;
        @(negedge clk);
        bus.cs_in = 1'b0;
        repeat (5) @(negedge clk);
        for (int b = 0; b < nsck; b++) begin
            if (mid_write && b == 4) begin
                bus.temp_in    = mid_val;
                bus.temp_valid = 1'b1;
            end
            if (mid_write && b > 4 && bus.temp_ready) rdy_blocked = 1'b0;
            if (!bus.sio_oe) oe_ok = 1'b0;
            data = {data[30:0], bus.sio_out};
            bus.sck_in = 1'b1;
            repeat (5) @(negedge clk);
            bus.sck_in = 1'b0;
            repeat (5) @(negedge clk);
        end
        bus.cs_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.frame_done) begin
                done_n++;
                if (pulse_at < 0) pulse_at = k;
            end
            if (bus.frame_abort) begin
                abort_n++;
                if (pulse_at < 0) pulse_at = k;
            end
            if (bus.temp_valid && bus.temp_ready && xfer_at < 0) xfer_at = k;
            else if (xfer_at >= 0) bus.temp_valid = 1'b0;
        end
        check_eq({tag, "_data"}, data, exp_data);
        check_eq({tag, "_oe_during"}, 32'(oe_ok), 32'd1);
        check_eq({tag, "_oe_after"}, 32'(bus.sio_oe), 32'd0);
        check_eq({tag, "_done_cnt"}, 32'(done_n), exp_done ? 32'd1 : 32'd0);
        check_eq({tag, "_abort_cnt"}, 32'(abort_n), exp_done ? 32'd0 : 32'd1);
        check_eq({tag, "_pulse_lat"}, 32'(pulse_at), 32'd3);
        if (mid_write) begin
            check_eq({tag, "_rdy_blocked"}, 32'(rdy_blocked), 32'd1);
            check_eq({tag, "_xfer_lat"}, 32'(xfer_at), 32'd3);
        end
    endtask

    initial begin
        bit oe_seen = 1'b0;
        rst_n          = 1'b0;
        bus.cs_in      = 1'b1;
        bus.sck_in     = 1'b0;
        bus.temp_valid = 1'b0;
        bus.temp_in    = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(bus.temp_ready), 32'd1);
        check_eq("rst_sio", 32'(bus.sio_out), 32'd0);
        check_eq("rst_oe", 32'(bus.sio_oe), 32'd0);
        check_eq("rst_done", 32'(bus.frame_done), 32'd0);
        check_eq("rst_abort", 32'(bus.frame_abort), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        write_word("w0d1f", 16'h0D1F);
        run_frame("f0d1f", 16, 32'h0D1F, 1'b1, 1'b0, 16'h0);

        write_word("w241f", 16'h241F);
        run_frame("f241f", 16, 32'h241F, 1'b1, 1'b0, 16'h0);
        write_word("w101f", 16'h101F);
        run_frame("f101f", 16, 32'h101F, 1'b1, 1'b0, 16'h0);

        // Write of FFFF issued mid-frame: old word returned, transfer lands after CS rise.
        run_frame("fmid", 16, 32'h101F, 1'b1, 1'b1, 16'hFFFF);
        repeat (3) @(negedge clk);
        run_frame("fffff", 16, 32'hFFFF, 1'b1, 1'b0, 16'h0);

        // Short frame aborts; following frame restarts from the MSB.
        write_word("w3c5a", 16'h3C5A);
        run_frame("fshort", 8, 32'h3C, 1'b0, 1'b0, 16'h0);
        run_frame("f3c5a", 16, 32'h3C5A, 1'b1, 1'b0, 16'h0);

        // Over-clocked frame: extra bits read as zero.
        write_word("waaaa", 16'hAAAA);
        run_frame("flong", 20, 32'hAAAA0, 1'b1, 1'b0, 16'h0);

        // Reset while bit 6 is on the wire with CS held low.
        write_word("w1234", 16'h1234);
        @(negedge clk);
        bus.cs_in = 1'b0;
        repeat (5) @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            bus.sck_in = 1'b1;
            repeat (5) @(negedge clk);
            bus.sck_in = 1'b0;
            repeat (5) @(negedge clk);
        end
        bus.sck_in = 1'b1;
        check_eq("mid_oe_before_rst", 32'(bus.sio_oe), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_oe", 32'(bus.sio_oe), 32'd0);
        bus.sck_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.sio_oe) oe_seen = 1'b1;
        end
        check_eq("no_frame_cs_low", 32'(oe_seen), 32'd0);
        check_eq("post_rst_ready", 32'(bus.temp_ready), 32'd1);
        bus.cs_in = 1'b1;
        repeat (8) @(negedge clk);
        run_frame("fpostrst", 16, 32'h0000, 1'b1, 1'b0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
